// File: rtl/shared_data_mem_responder_if.sv
// Core-side data-memory bus for the shared responder: per-port command/address/data in, read data/done/error out.
// Flat per-port packing: port i occupies Control[2i+:2], DataAddr/DataIn/DataOut[16i+:16].
interface shared_data_mem_responder_if #(
   parameter int NUM_PORTS = 4
);
   logic [2*NUM_PORTS-1:0]  Control;
   logic [16*NUM_PORTS-1:0] DataAddr;
   logic [16*NUM_PORTS-1:0] DataIn;
   logic [16*NUM_PORTS-1:0] DataOut;
   logic [NUM_PORTS-1:0]    Done;
   logic                    Busy;
   logic [NUM_PORTS-1:0]    Err;

   modport master (
      output Control, DataAddr, DataIn,
      input  DataOut, Done, Busy, Err
   );

   modport slave (
      input  Control, DataAddr, DataIn,
      output DataOut, Done, Busy, Err
   );
endinterface

// File: rtl/shared_data_mem_responder.sv
// Round-robin responder serving NUM_PORTS cores from one single-port RAM; 3 cycles per access, Done pulses when served.
// Cores hold requests until their Done, so waiting requests are never dropped; BOUNDS_CHECK_EN adds out-of-range Err.
module shared_data_mem_responder #(
   parameter int NUM_PORTS = 4,
   parameter int DEPTH     = 1024,
   parameter int AW        = 10
) (
   input logic                        clock,
   input logic                        resetn,
   shared_data_mem_responder_if.slave bus
);
   localparam int         PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [1:0] CMD_RD = 2'b01;
   localparam logic [1:0] CMD_WR = 2'b10;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                     state;
   state_t                     state_nxt;
   logic                       busy;
   logic                       req_any;
   logic [PW-1:0]              grant_nxt;
   logic [15:0]                addr_full;
   logic [PW-1:0]              rr_ptr;
   logic [PW-1:0]              grant_q;
   logic [1:0]                 cmd_q;
   logic [AW-1:0]              addr_q;
   logic [15:0]                data_q;
   logic [15:0]                rd_q;
   logic [NUM_PORTS-1:0][15:0] dout_q;
   logic [NUM_PORTS-1:0]       done_q;
   logic                       access_en;
   logic [15:0]                mem [DEPTH];

`ifdef BOUNDS_CHECK_EN
   logic                       oob_q;
   logic [NUM_PORTS-1:0]       err_q;

   assign access_en = !oob_q;
   assign bus.Err   = err_q;
`else
   logic                       unused_addr_hi;

   assign access_en      = 1'b1;
   assign unused_addr_hi = ^addr_full[15:AW];
   assign bus.Err        = '0;
`endif

   // First requesting port at or after rr_ptr, wrapping at NUM_PORTS.
   always_comb begin
      int idx;
      idx       = 0;
      req_any   = 1'b0;
      grant_nxt = rr_ptr;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!req_any && (bus.Control[2*idx +: 2] == CMD_RD || bus.Control[2*idx +: 2] == CMD_WR)) begin
            req_any   = 1'b1;
            grant_nxt = PW'(idx);
         end
      end
      addr_full = bus.DataAddr[int'(grant_nxt)*16 +: 16];
   end

   always_ff @(posedge clock) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      case (state)
         IDLE:    if (req_any) state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         rr_ptr  <= '0;
         grant_q <= '0;
         cmd_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         dout_q  <= '0;
         done_q  <= '0;
`ifdef BOUNDS_CHECK_EN
         oob_q   <= 1'b0;
         err_q   <= '0;
`endif
      end else begin
         done_q <= '0;
         case (state)
            IDLE: if (req_any) begin
               grant_q <= grant_nxt;
               cmd_q   <= bus.Control[int'(grant_nxt)*2 +: 2];
               addr_q  <= addr_full[AW-1:0];
               data_q  <= bus.DataIn[int'(grant_nxt)*16 +: 16];
`ifdef BOUNDS_CHECK_EN
               oob_q   <= (addr_full[15:AW] != '0);
`endif
            end
            RESP: begin
               if (cmd_q == CMD_RD && access_en) dout_q[grant_q] <= rd_q;
               done_q[grant_q] <= 1'b1;
`ifdef BOUNDS_CHECK_EN
               err_q[grant_q]  <= oob_q;
`endif
               if (grant_q == PW'(NUM_PORTS - 1)) rr_ptr <= '0;
               else                               rr_ptr <= grant_q + PW'(1);
            end
            default: ;
         endcase
      end
   end

   // RAM kept free of reset so it maps to a plain single-port macro; reset still blocks a pending write.
   always_ff @(posedge clock) begin
      if (resetn && state == ACCESS && access_en) begin
         if (cmd_q == CMD_WR) mem[addr_q] <= data_q;
         else                 rd_q <= mem[addr_q];
      end
   end

   assign bus.DataOut = dout_q;
   assign bus.Done    = done_q;
   assign bus.Busy    = busy;
endmodule

// File: tb/tb_shared_data_mem_responder.sv
// Directed bench for shared_data_mem_responder: inputs driven and outputs sampled on the falling clock edge.
module tb_shared_data_mem_responder;
   localparam int         NP = 4;
   localparam logic [1:0] RD = 2'b01;
   localparam logic [1:0] WR = 2'b10;

   logic clock = 1'b0;
   logic resetn;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   shared_data_mem_responder_if #(.NUM_PORTS(NP)) bus ();

   shared_data_mem_responder #(.NUM_PORTS(NP), .DEPTH(1024), .AW(10)) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic set_req(input int p, input logic [1:0] c, input logic [15:0] a, input logic [15:0] d);
      bus.Control[2*p +: 2]   = c;
      bus.DataAddr[16*p +: 16] = a;
      bus.DataIn[16*p +: 16]   = d;
   endtask

   function automatic logic [15:0] dout(input int p);
      return bus.DataOut[16*p +: 16];
   endfunction

   // Returns the falling edge count at which Done[p] was seen (-1 on timeout) and drops that request.
   task automatic wait_done(input int p, input int max_cyc, output int cyc);
      cyc = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         @(negedge clock);
         if (bus.Done[p]) begin
            cyc = i;
            bus.Control[2*p +: 2] = 2'b00;
            break;
         end
      end
   endtask

   task automatic test_reset;
      int cyc;
      resetn       = 1'b0;
      bus.Control  = '0;
      bus.DataAddr = '0;
      bus.DataIn   = '0;
      set_req(0, WR, 16'd0, 16'h0F0F);
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      total_cnt++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.Busy); else pass_cnt++;
      total_cnt++; if (bus.Done !== 4'b0) $display("FAIL reset_done got %b want 0000", bus.Done); else pass_cnt++;
      total_cnt++; if (bus.DataOut !== 64'h0) $display("FAIL reset_dataout got %h want 0", bus.DataOut); else pass_cnt++;
      total_cnt++; if (bus.Err !== 4'b0) $display("FAIL reset_err got %b want 0000", bus.Err); else pass_cnt++;
      resetn = 1'b1;
      @(negedge clock);
      total_cnt++; if (bus.Busy !== 1'b1) $display("FAIL busy_after_release got %b want 1", bus.Busy); else pass_cnt++;
      wait_done(0, 10, cyc);
      total_cnt++; if (cyc !== 2) $display("FAIL first_grant_latency got %0d want 2", cyc); else pass_cnt++;
      @(negedge clock);
   endtask

   task automatic test_single_port;
      int cyc;
      set_req(0, WR, 16'd5, 16'hBEEF);
      wait_done(0, 10, cyc);
      total_cnt++; if (cyc !== 3) $display("FAIL single_wr_latency got %0d want 3", cyc); else pass_cnt++;
      total_cnt++; if (bus.Done !== 4'b0001) $display("FAIL single_wr_done got %b want 0001", bus.Done); else pass_cnt++;
      total_cnt++; if (dout(0) !== 16'h0000) $display("FAIL write_keeps_dataout got %h want 0000", dout(0)); else pass_cnt++;
      @(negedge clock);
      total_cnt++; if (bus.Done !== 4'b0000) $display("FAIL done_one_cycle got %b want 0000", bus.Done); else pass_cnt++;
      set_req(0, RD, 16'd5, 16'h0);
      wait_done(0, 10, cyc);
      total_cnt++; if (cyc !== 3) $display("FAIL single_rd_latency got %0d want 3", cyc); else pass_cnt++;
      total_cnt++; if (dout(0) !== 16'hBEEF) $display("FAIL single_rd_data got %h want beef", dout(0)); else pass_cnt++;
      @(negedge clock);
   endtask

   task automatic test_round_robin;
      int          cyc;
      int          n;
      int          order [NP];
      int          tdone [NP];
      logic [15:0] v;
      // Port 3 accesses leave rr_ptr at 0 and preload addresses 10..13.
      for (int i = 0; i < NP; i++) begin
         v = 16'(16'hA0A0 + 16'h0101 * i);
         set_req(3, WR, 16'(10 + i), v);
         wait_done(3, 10, cyc);
         total_cnt++; if (cyc !== 3) $display("FAIL preload_latency_%0d got %0d want 3", i, cyc); else pass_cnt++;
         @(negedge clock);
      end
      for (int i = 0; i < NP; i++) begin
         order[i] = -1;
         tdone[i] = -1;
         set_req(i, RD, 16'(10 + i), 16'h0);
      end
      n = 0;
      for (int c = 1; c <= 30 && n < NP; c++) begin
         @(negedge clock);
         if (bus.Done !== 4'b0) begin
            total_cnt++; if (!$onehot(bus.Done)) $display("FAIL rr_done_onehot got %b want one bit", bus.Done); else pass_cnt++;
            for (int p = 0; p < NP; p++) begin
               if (bus.Done[p] && n < NP) begin
                  order[n] = p;
                  tdone[n] = c;
                  n++;
                  bus.Control[2*p +: 2] = 2'b00;
               end
            end
         end
      end
      for (int i = 0; i < NP; i++) begin
         v = 16'(16'hA0A0 + 16'h0101 * i);
         total_cnt++; if (order[i] !== i) $display("FAIL rr_order_%0d got %0d want %0d", i, order[i], i); else pass_cnt++;
         total_cnt++; if (tdone[i] !== 3 + 3 * i) $display("FAIL rr_time_%0d got %0d want %0d", i, tdone[i], 3 + 3 * i); else pass_cnt++;
         total_cnt++; if (dout(i) !== v) $display("FAIL rr_data_%0d got %h want %h", i, dout(i), v); else pass_cnt++;
      end
      @(negedge clock);
      // rr_ptr is 0 again; port 1 alone must still be served promptly.
      set_req(1, RD, 16'd11, 16'h0);
      wait_done(1, 10, cyc);
      total_cnt++; if (cyc !== 3) $display("FAIL rr_port1_alone got %0d want 3", cyc); else pass_cnt++;
      @(negedge clock);
      set_req(3, WR, 16'd13, 16'hA3A3);
      wait_done(3, 10, cyc);
      @(negedge clock);
      set_req(0, RD, 16'd10, 16'h0);
      set_req(1, RD, 16'd11, 16'h0);
      wait_done(0, 10, cyc);
      total_cnt++; if (cyc !== 3) $display("FAIL rr_port0_first got %0d want 3", cyc); else pass_cnt++;
      wait_done(1, 10, cyc);
      total_cnt++; if (cyc !== 3) $display("FAIL rr_port1_next got %0d want 3", cyc); else pass_cnt++;
      @(negedge clock);
   endtask

   task automatic test_raw;
      int cyc;
      // rr_ptr is 2 here, so the port 2 write goes ahead of the port 3 read.
      set_req(2, WR, 16'd7, 16'h1234);
      set_req(3, RD, 16'd7, 16'h0);
      wait_done(2, 10, cyc);
      total_cnt++; if (cyc !== 3) $display("FAIL raw_write_latency got %0d want 3", cyc); else pass_cnt++;
      wait_done(3, 10, cyc);
      total_cnt++; if (cyc !== 3) $display("FAIL raw_read_spacing got %0d want 3", cyc); else pass_cnt++;
      total_cnt++; if (dout(3) !== 16'h1234) $display("FAIL raw_data got %h want 1234", dout(3)); else pass_cnt++;
      total_cnt++; if (dout(2) !== 16'hA2A2) $display("FAIL raw_writer_dataout got %h want a2a2", dout(2)); else pass_cnt++;
      @(negedge clock);
   endtask

   task automatic test_reset_abort;
      int cyc;
      int seen;
      set_req(0, WR, 16'd9, 16'h5555);
      wait_done(0, 10, cyc);
      @(negedge clock);
      set_req(0, WR, 16'd9, 16'hAAAA);
      @(negedge clock);
      total_cnt++; if (bus.Busy !== 1'b1) $display("FAIL abort_in_access got %b want 1", bus.Busy); else pass_cnt++;
      resetn = 1'b0;
      set_req(0, 2'b00, 16'd0, 16'h0);
      @(negedge clock);
      total_cnt++; if (bus.Busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.Busy); else pass_cnt++;
      total_cnt++; if (dout(3) !== 16'h0000) $display("FAIL abort_dataout_cleared got %h want 0000", dout(3)); else pass_cnt++;
      resetn = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (bus.Done !== 4'b0) seen++;
      end
      total_cnt++; if (seen !== 0) $display("FAIL abort_no_done got %0d pulses want 0", seen); else pass_cnt++;
      set_req(0, RD, 16'd9, 16'h0);
      wait_done(0, 10, cyc);
      total_cnt++; if (cyc !== 3) $display("FAIL abort_read_latency got %0d want 3", cyc); else pass_cnt++;
      total_cnt++; if (dout(0) !== 16'h5555) $display("FAIL abort_write_dropped got %h want 5555", dout(0)); else pass_cnt++;
      @(negedge clock);
   endtask

   task automatic test_bounds;
      int cyc;
      set_req(0, RD, 16'h0400, 16'h0);
      wait_done(0, 10, cyc);
      total_cnt++; if (cyc !== 3) $display("FAIL bounds_latency got %0d want 3", cyc); else pass_cnt++;
`ifdef BOUNDS_CHECK_EN
      total_cnt++; if (bus.Err[0] !== 1'b1) $display("FAIL bounds_err got %b want 1", bus.Err[0]); else pass_cnt++;
      total_cnt++; if (dout(0) !== 16'h5555) $display("FAIL bounds_dataout_kept got %h want 5555", dout(0)); else pass_cnt++;
      @(negedge clock);
      set_req(0, RD, 16'd5, 16'h0);
      wait_done(0, 10, cyc);
      total_cnt++; if (bus.Err[0] !== 1'b0) $display("FAIL bounds_err_clear got %b want 0", bus.Err[0]); else pass_cnt++;
      total_cnt++; if (dout(0) !== 16'hBEEF) $display("FAIL bounds_next_read got %h want beef", dout(0)); else pass_cnt++;
`else
      total_cnt++; if (bus.Err !== 4'b0) $display("FAIL alias_err got %b want 0000", bus.Err); else pass_cnt++;
      total_cnt++; if (dout(0) !== 16'h0F0F) $display("FAIL alias_data got %h want 0f0f", dout(0)); else pass_cnt++;
`endif
      @(negedge clock);
   endtask

   task automatic test_idle_codes;
      int seen;
      set_req(1, 2'b11, 16'd5, 16'h0);
      set_req(2, 2'b00, 16'd5, 16'h0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (bus.Busy !== 1'b0 || bus.Done !== 4'b0) seen++;
      end
      total_cnt++; if (seen !== 0) $display("FAIL idle_codes got %0d active cycles want 0", seen); else pass_cnt++;
      set_req(1, 2'b00, 16'd0, 16'h0);
   endtask

   initial begin
      test_reset();
      test_single_port();
      test_round_robin();
      test_raw();
      test_reset_abort();
      test_bounds();
      test_idle_codes();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
